module_display_mux: RTL and testbench
=====================================

MODULE_DISPLAY_MUX -- requirements
Module: module_display_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed common-anode digits (range 1..8).
REQ-002 Parameter REFRESH_DIV, default 100000, clock cycles each digit is held (minimum GUARD+2).
REQ-003 Parameter GUARD, default 2, blanking cycles at the start of each digit slot (anti-ghosting).
REQ-004 clk  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 en  in  1  display enable; 0 SHALL blank all digits.
REQ-007 load  in  1  one-cycle strobe capturing data/dp into the holding register.
REQ-008 data  in  4*NUM_DIGITS  hex nibbles; nibble k (bits 4k+3:4k) drives digit k, where digit 0 is the rightmost.
REQ-009 dp  in  NUM_DIGITS  decimal point per digit; 1 = lit.
REQ-010 lzs  in  1  leading-zero suppression mode.
REQ-011 seg  out  8  registered segments {dp,g,f,e,d,c,b,a}, active low.
REQ-012 an  out  NUM_DIGITS  registered anode selects, active low, at most one low at any time.

Function
REQ-013 Holding register SHALL update only on clock edges with load=1; the display SHALL show only holding-register contents.
REQ-014 Decode (gfedcba, hex, active low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-015 seg[7] SHALL be 0 when the current digit's held dp is 1, else 1.
REQ-016 FSM states are IDLE, GUARD, SHOW.
REQ-017 IDLE: an all 1, seg=FF; IDLE->GUARD when en=1.
REQ-018 GUARD: an all 1, seg=FF for exactly GUARD cycles, then ->SHOW.
REQ-019 SHOW: an[idx]=0, seg=decode(held nibble idx) for REFRESH_DIV-GUARD cycles, then idx advances and ->GUARD.
REQ-020 Digit index SHALL wrap from NUM_DIGITS-1 to 0.
REQ-021 en=0 in any state SHALL go to IDLE on the next edge; it SHALL reset the cycle counter and set idx=0.
REQ-022 With lzs=1, digit k>0 SHALL be blanked (seg[6:0]=7F) when held nibbles k..NUM_DIGITS-1 are all zero.
REQ-023 With lzs=1, a suppressed digit's dp SHALL still be shown, and digit 0 SHALL never be suppressed.
REQ-024 A load during SHOW SHALL take effect on seg the cycle after the capturing edge, with no change to slot timing.
REQ-025 Outputs SHALL be registered: state, idx, and held-data changes appear on seg/an one cycle later.
REQ-026 Full refresh period SHALL be NUM_DIGITS*REFRESH_DIV cycles; each digit's lit time is REFRESH_DIV-GUARD cycles.
REQ-027 NUM_DIGITS=1 SHALL still run GUARD/SHOW cycling on an[0].

Reset
REQ-028 rst=1 SHALL force state=IDLE, idx=0, counter=0, holding register data=0 and dp=0, seg=FF, an all 1 at the next edge.
REQ-029 rst SHALL take priority over load and en on the same edge.
REQ-030 rst asserted mid-slot SHALL abort the slot; after release with en=1, the first digit lit SHALL be digit 0, preceded by a full GUARD.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2)
REQ-031 Reset, en=1, load data=16'h1234, dp=0 -> per 8-cycle slot: 2 blank cycles, then 6 cycles with an=1110 seg=99 (4), then an=1101 seg=B0 (3), an=1011 seg=A4 (2), an=0111 seg=F9 (1), repeating.
REQ-032 load data=16'h00A0, dp=4'b0100, lzs=1 -> digit 0: seg=C0; digit 1: seg=88; digit 2: seg=7F (dp lit, blank); digit 3: seg=FF.
REQ-033 Same as REQ-032 with lzs=0 -> digit 2: seg=40 and digit 3: seg=C0.
REQ-034 en dropped during digit 2 SHOW -> next cycle an=1111 seg=FF; re-enable -> 2 guard cycles, then digit 0 lit.
REQ-035 rst pulsed while load=1 with data=FFFF -> holding register remains 0; after release digit 0 shows seg=C0.
REQ-036 Over 1000 cycles of random load/en/lzs, checker SHALL confirm that at most one an bit is low, and that all an bits are high during GUARD.

Source files
------------

// File: rtl/module_display_mux.sv
// module_display_mux: time-multiplexed common-anode 7-segment driver with guard blanking and leading-zero suppression
// ports: clk, rst (sync, active high), en (display enable), load (capture strobe),
//        data (nibble k -> digit k, digit 0 rightmost), dp (per-digit point, 1 = lit),
//        lzs (leading-zero suppression), seg {dp,g..a} active low, an active low one-cold
module module_display_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    lzs,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(REFRESH_DIV);
    typedef enum logic [1:0] {S_IDLE, S_GUARD, S_SHOW} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] idx, idx_n;
    logic [4*NUM_DIGITS-1:0] held_data;
    logic [NUM_DIGITS-1:0] held_dp;
    logic [3:0] nib;
    logic sup;
    function automatic logic [6:0] dec(input logic [3:0] h);
        case (h)
            4'h0: dec = 7'h40;
            4'h1: dec = 7'h79;
            4'h2: dec = 7'h24;
            4'h3: dec = 7'h30;
            4'h4: dec = 7'h19;
            4'h5: dec = 7'h12;
            4'h6: dec = 7'h02;
            4'h7: dec = 7'h78;
            4'h8: dec = 7'h00;
            4'h9: dec = 7'h10;
            4'hA: dec = 7'h08;
            4'hB: dec = 7'h03;
            4'hC: dec = 7'h46;
            4'hD: dec = 7'h21;
            4'hE: dec = 7'h06;
            default: dec = 7'h0E;
        endcase
    endfunction
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        if (!en) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            idx_n   = '0;
        end else if (state == S_IDLE) begin
            state_n = S_GUARD;
            cnt_n   = '0;
        end else if (state == S_GUARD && cnt == CW'(GUARD - 1)) begin
            state_n = S_SHOW;
            cnt_n   = '0;
        end else if (state == S_SHOW && cnt == CW'(REFRESH_DIV - GUARD - 1)) begin
            state_n = S_GUARD;
            cnt_n   = '0;
            idx_n   = idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
        end
    end
    // a digit is a leading zero when it and every digit to its left hold zero
    assign nib = held_data[{idx, 2'b00} +: 4];
    assign sup = lzs && idx != '0 && (held_data >> {idx, 2'b00}) == '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            held_data <= '0;
            held_dp   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            if (load) begin
                held_data <= data;
                held_dp   <= dp;
            end
        end
    end
    // outputs follow the registered state one cycle later; dropping en blanks at once
    always_ff @(posedge clk) begin
        if (rst || !en || state != S_SHOW) begin
            seg <= 8'hFF;
            an  <= '1;
        end else begin
            seg <= {~held_dp[idx], sup ? 7'h7F : dec(nib)};
            an  <= ~(NUM_DIGITS'(1) << idx);
        end
    end
endmodule

// File: tb/tb_module_display_mux.sv
// tb_module_display_mux: randomized scoreboard bench for module_display_mux
module tb_module_display_mux;
    localparam int N  = 4;
    localparam int RD = 8;
    localparam int G  = 2;
    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] an;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, load = 1'b0, lzs = 1'b0;
    logic [15:0] data = '0;
    logic [3:0] dp = '0;
    logic [7:0] seg;
    logic [3:0] an;
    int total = 0, bad = 0;
    logic [15:0] m_data = '0;
    logic [3:0] m_dp = '0;
    int k = 0;
    int p, d;
    exp_t e, ev;
    exp_t q[$];
    logic [6:0] tbl[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    module_display_mux #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GUARD(G)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .data(data),
        .dp(dp), .lzs(lzs), .seg(seg), .an(an)
    );
    always #5 clk = ~clk;
    // k counts consecutive enabled edges; the display runs a fixed RD-cycle slot
    // per digit, blank for the first G cycles, and outputs show the pre-edge view
    always @(posedge clk) begin
        e = '{8'hFF, 4'hF};
        if (!rst && en && k > 0) begin
            p = k - 1;
            if (p % RD >= G) begin
                d = (p / RD) % N;
                e.an = ~(4'b1 << d);
                e.seg[7] = ~m_dp[d];
                e.seg[6:0] = (lzs && d > 0 && (m_data >> (4 * d)) == 0) ? 7'h7F : tbl[m_data[4*d+:4]];
            end
        end
        if (rst) begin
            m_data = '0;
            m_dp = '0;
            k = 0;
        end else begin
            if (load) begin
                m_data = data;
                m_dp = dp;
            end
            k = en ? k + 1 : 0;
        end
        q.push_back(e);
    end
    always @(negedge clk) begin
        if (q.size() > 0) begin
            ev = q.pop_front();
            total++;
            if ({seg, an} !== ev) begin
                bad++;
                $display("FAIL scoreboard t=%0t got seg=%h an=%b expected seg=%h an=%b", $time, seg, an, ev.seg, ev.an);
            end
            total++;
            if ($countones(~an) > 1) begin
                bad++;
                $display("FAIL one_anode t=%0t got an=%b expected at most one low", $time, an);
            end
        end
    end
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask
    initial begin
        load = 1'b1;
        data = 16'hFFFF;
        dp = 4'hF;
        en = 1'b1;
        cyc(2);
        rst = 1'b0;
        load = 1'b0;
        cyc(12);
        load = 1'b1;
        data = 16'h1234;
        dp = 4'h0;
        cyc(1);
        load = 1'b0;
        cyc(40);
        load = 1'b1;
        data = 16'h00A0;
        dp = 4'b0100;
        lzs = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(34);
        lzs = 1'b0;
        cyc(34);
        for (int i = 0; i < 40 && an !== 4'b1011; i++) cyc(1);
        cyc(2);
        en = 1'b0;
        cyc(3);
        en = 1'b1;
        cyc(30);
        for (int i = 0; i < 1000; i++) begin
            rst = $urandom % 200 == 0;
            en = $urandom % 40 != 0;
            load = $urandom % 8 == 0;
            data = $urandom_range(0, 2) == 0 ? 16'($urandom & 32'h00FF) : 16'($urandom);
            dp = 4'($urandom);
            lzs = 1'($urandom);
            cyc(1);
        end
        rst = 1'b0;
        en = 1'b1;
        load = 1'b0;
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
